palu_issue: RTL

//  Issue stage directly upstream of the palu ALU pipeline. Buffers incoming

---
 rtl/palu_pkg.sv | 40 ++++
 rtl/palu_issue_fifo.sv | 57 +++++
 rtl/palu_issue.sv | 85 ++++++++
 3 files changed

// File: rtl/palu_pkg.sv
// Shared palu definitions: opcode encoding, instruction layout and the
// per-opcode source-register usage used by issue-time hazard detection.
package palu_pkg;

   localparam int OP_W    = 3;
   localparam int REG_W   = 3;
   localparam int INSTR_W = OP_W + 3 * REG_W;

   localparam logic [OP_W-1:0] ZERO = 3'd0;
   localparam logic [OP_W-1:0] ONE  = 3'd1;
   localparam logic [OP_W-1:0] ADD  = 3'd2;
   localparam logic [OP_W-1:0] SUB  = 3'd3;
   localparam logic [OP_W-1:0] NAND = 3'd4;
   localparam logic [OP_W-1:0] SRL  = 3'd5;
   localparam logic [OP_W-1:0] CPA  = 3'd6;
   localparam logic [OP_W-1:0] NOT  = 3'd7;

   typedef struct packed {
      logic [OP_W-1:0]  op;
      logic [REG_W-1:0] src1;
      logic [REG_W-1:0] src2;
      logic [REG_W-1:0] dest;
   } instr_t;

   // Constant generators read nothing, so they can never be RAW-dependent.
   function automatic logic uses_src1(input logic [OP_W-1:0] op);
      case (op)
         ADD, SUB, NAND, SRL, CPA, NOT: uses_src1 = 1'b1;
         default:                       uses_src1 = 1'b0;
      endcase
   endfunction

   function automatic logic uses_src2(input logic [OP_W-1:0] op);
      case (op)
         ADD, SUB, NAND: uses_src2 = 1'b1;
         default:        uses_src2 = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/palu_issue_fifo.sv
// Synchronous instruction FIFO feeding the issue stage. Head is the oldest
// entry; push while full and pop while empty are ignored.
module palu_issue_fifo
   import palu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic   clock,
   input  logic   reset_n,
   input  logic   push,
   input  logic   pop,
   input  instr_t wdata,
   output instr_t head,
   output logic   full,
   output logic   empty
);

   localparam int PW = $clog2(DEPTH);

   instr_t          mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [PW:0]     count;
   logic            do_push;
   logic            do_pop;

   assign full    = (count == (PW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   // Storage needs no reset: pointers and count define what is valid.
   always_ff @(posedge clock) begin
      if (do_push)
         mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/palu_issue.sv
// Issue stage in front of the palu ALU: queues instructions, inserts a single
// bubble on a RAW dependency against the previous issue, and counts events.
module palu_issue
   import palu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  in_opcode,
   input  logic [REG_W-1:0] in_src1,
   input  logic [REG_W-1:0] in_src2,
   input  logic [REG_W-1:0] in_dest,
   output logic             stall,
   output logic [OP_W-1:0]  opcode,
   output logic [REG_W-1:0] src1,
   output logic [REG_W-1:0] src2,
   output logic [REG_W-1:0] dest,
   output logic [CNT_W-1:0] issue_cnt,
   output logic [CNT_W-1:0] hazard_cnt
);

   instr_t           wdata;
   instr_t           head;
   logic             full;
   logic             empty;
   logic             hazard;
   logic             issue;
   logic             last_valid;
   logic [REG_W-1:0] last_dest;

   assign wdata    = '{op: in_opcode, src1: in_src1, src2: in_src2, dest: in_dest};
   assign in_ready = ~full;

   palu_issue_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .push    (in_valid & in_ready),
      .pop     (issue),
      .wdata   (wdata),
      .head    (head),
      .full    (full),
      .empty   (empty)
   );

   // A bubble clears last_valid, so a stalled head always issues next cycle.
   assign hazard = last_valid &
                   ((uses_src1(head.op) & (head.src1 == last_dest)) |
                    (uses_src2(head.op) & (head.src2 == last_dest)));
   assign issue  = ~empty & ~hazard;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         stall      <= 1'b1;
         opcode     <= '0;
         src1       <= '0;
         src2       <= '0;
         dest       <= '0;
         last_valid <= 1'b0;
         last_dest  <= '0;
         issue_cnt  <= '0;
         hazard_cnt <= '0;
      end else if (empty) begin
         stall      <= 1'b1;
         last_valid <= 1'b0;
      end else if (hazard) begin
         stall      <= 1'b1;
         last_valid <= 1'b0;
         hazard_cnt <= hazard_cnt + CNT_W'(1);
      end else begin
         stall      <= 1'b0;
         opcode     <= head.op;
         src1       <= head.src1;
         src2       <= head.src2;
         dest       <= head.dest;
         last_dest  <= head.dest;
         last_valid <= 1'b1;
         issue_cnt  <= issue_cnt + CNT_W'(1);
      end
   end

endmodule
